// File: rtl/tc_dev_pkg.sv
// Shared definitions for the countdown timer peripheral:
// FSM encodings, register word offsets and CTRL bit positions.
package tc_dev_pkg;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_load = 2'd1,
      st_cnt  = 2'd2,
      st_int  = 2'd3
   } state_t;

   // Register word offsets (byte address bits [3:2])
   localparam logic [1:0] addr_ctrl   = 2'd0;
   localparam logic [1:0] addr_preset = 2'd1;
   localparam logic [1:0] addr_count  = 2'd2;
   localparam logic [1:0] addr_rsvd   = 2'd3;

   // CTRL bit positions
   localparam int ctrl_en      = 0;
   localparam int ctrl_mode_lo = 1;
   localparam int ctrl_mode_hi = 2;
   localparam int ctrl_im      = 3;
   localparam int ctrl_w       = 4;

   localparam logic [1:0] mode_auto = 2'b01;

   // Only the exact auto-reload encoding reloads; 10/11 fall back to one-shot
   function automatic logic mode_is_auto(input logic [1:0] mode);
      return (mode == mode_auto);
   endfunction

endpackage

// File: rtl/tc_dev_if.sv
// Data-side load/store bus between the core (master) and a peripheral (slave).
interface tc_dev_if #(
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic [1:0]    addr;
   logic [DW-1:0] wdata;
   logic          ack;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/tc_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers on the
// load/store bus, a four-state countdown FSM and a maskable interrupt.
module tc_dev
   import tc_dev_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic  clk,
   input  logic  rst,
   tc_dev_if.slave bus,
   output logic  irq
);

   localparam logic [DW-1:0] one_val = {{(DW-1){1'b0}}, 1'b1};

   state_t              state_reg,  state_next;
   logic [ctrl_w-1:0]   ctrl_reg,   ctrl_next;
   logic [DW-1:0]       preset_reg, preset_next;
   logic [DW-1:0]       count_reg,  count_next;
   logic                flag_reg,   flag_next;
   logic                pulse_reg,  pulse_next;
   logic                ack_reg,    ack_next;
   logic [DW-1:0]       rdata_reg,  rdata_next;

   logic wr_access;
   logic rd_access;
   logic ctrl_wr;
   logic en;

   assign wr_access = bus.req &  bus.we;
   assign rd_access = bus.req & ~bus.we;
   assign ctrl_wr   = wr_access && (bus.addr == addr_ctrl);
   assign en        = ctrl_reg[ctrl_en];

   // Next-state, register-file and bus-response logic
   always_comb begin
      state_next  = state_reg;
      ctrl_next   = ctrl_reg;
      preset_next = preset_reg;
      count_next  = count_reg;
      flag_next   = flag_reg;
      pulse_next  = 1'b0;
      ack_next    = bus.req;
      rdata_next  = '0;

      // Auto-reload interrupt is a single-cycle pulse: drop it after INT
      if (pulse_reg) begin
         flag_next = 1'b0;
      end

      // Bus writes; COUNT and the reserved slot are acked but ignored
      if (wr_access) begin
         case (bus.addr)
            addr_ctrl: begin
               ctrl_next = bus.wdata[ctrl_w-1:0];
               flag_next = 1'b0;
            end
            addr_preset: preset_next = bus.wdata;
            default: ;
         endcase
      end

      // Reads return the pre-edge register value; writes return 0
      if (rd_access) begin
         case (bus.addr)
            addr_ctrl:   rdata_next = {{(DW-ctrl_w){1'b0}}, ctrl_reg};
            addr_preset: rdata_next = preset_reg;
            addr_count:  rdata_next = count_reg;
            default:     rdata_next = '0;
         endcase
      end

      // Countdown FSM works from the registered CTRL value
      case (state_reg)
         st_idle: begin
            if (en) begin
               state_next = st_load;
            end
         end
         st_load: begin
            if (!en) begin
               state_next = st_idle;
            end else begin
               count_next = preset_reg;
               state_next = st_cnt;
            end
         end
         st_cnt: begin
            if (!en) begin
               state_next = st_idle;
            end else if (count_reg > one_val) begin
               count_next = count_reg - one_val;
            end else begin
               count_next = '0;
               state_next = st_int;
            end
         end
         st_int: begin
            // INT always completes; its flag set overrides a same-cycle CTRL write
            flag_next = 1'b1;
            if (mode_is_auto(ctrl_reg[ctrl_mode_hi:ctrl_mode_lo])) begin
               pulse_next = 1'b1;
               state_next = st_load;
            end else begin
               // A CTRL write landing in this cycle carries newer software intent
               if (!ctrl_wr) begin
                  ctrl_next[ctrl_en] = 1'b0;
               end
               state_next = st_idle;
            end
         end
         default: state_next = st_idle;
      endcase
   end

   // State and register update with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= st_idle;
         ctrl_reg   <= '0;
         preset_reg <= '0;
         count_reg  <= '0;
         flag_reg   <= 1'b0;
         pulse_reg  <= 1'b0;
         ack_reg    <= 1'b0;
         rdata_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         ctrl_reg   <= ctrl_next;
         preset_reg <= preset_next;
         count_reg  <= count_next;
         flag_reg   <= flag_next;
         pulse_reg  <= pulse_next;
         ack_reg    <= ack_next;
         rdata_reg  <= rdata_next;
      end
   end

   assign bus.ack   = ack_reg;
   assign bus.rdata = rdata_reg;
   assign irq       = flag_reg & ctrl_reg[ctrl_im];

endmodule

// File: tb/tb_tc_dev.sv
// Directed bench for the countdown timer: reset, one-shot, auto-reload,
// masked interrupt, disable mid-count, bus corner cases and async reset.
module tb_tc_dev;
   import tc_dev_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic irq;

   int n_checks = 0;
   int n_fail   = 0;

   tc_dev_if #(.DW(32)) bus_if ();

   tc_dev #(.DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if),
      .irq (irq)
   );

   always #5 clk = ~clk;

   // One bus transaction: drive at negedge, sample response 1 ns after the edge
   task automatic bus_op(input logic w, input logic [1:0] a, input logic [31:0] d,
                         output logic ack_o, output logic [31:0] rd_o);
      @(negedge clk);
      bus_if.req   = 1'b1;
      bus_if.we    = w;
      bus_if.addr  = a;
      bus_if.wdata = d;
      @(posedge clk);
      #1;
      ack_o = bus_if.ack;
      rd_o  = bus_if.rdata;
      bus_if.req = 1'b0;
      bus_if.we  = 1'b0;
      $display("[%0t] %s addr=%0d wdata=%0h -> ack=%0b rdata=%0h irq=%0b",
               $time, w ? "WR" : "RD", a, d, ack_o, rd_o, irq);
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic        ack_s;
      logic [31:0] rd_s;
      repeat (3) idle_cycle();
      n_checks++; if (bus_if.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %0b expected 0", bus_if.ack); end
      n_checks++; if (bus_if.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %0h expected 0", bus_if.rdata); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_op(1'b0, 2'(i), 32'h0, ack_s, rd_s);
         n_checks++; if (ack_s !== 1'b1) begin n_fail++; $display("FAIL reset_read_ack[%0d]: got %0b expected 1", i, ack_s); end
         n_checks++; if (rd_s !== 32'h0) begin n_fail++; $display("FAIL reset_read_data[%0d]: got %0h expected 0", i, rd_s); end
      end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_read_irq: got %0b expected 0", irq); end
   endtask

   task automatic test_oneshot();
      logic        ack_s;
      logic [31:0] rd_s;
      logic [31:0] exp_cnt [8];
      exp_cnt = '{32'd0, 32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
      bus_op(1'b1, addr_preset, 32'd5, ack_s, rd_s);
      bus_op(1'b1, addr_ctrl, 32'h9, ack_s, rd_s);
      for (int i = 0; i < 8; i++) begin
         bus_op(1'b0, addr_count, 32'h0, ack_s, rd_s);
         n_checks++; if (rd_s !== exp_cnt[i]) begin n_fail++; $display("FAIL oneshot_count[%0d]: got %0d expected %0d", i, rd_s, exp_cnt[i]); end
         n_checks++; if (irq !== (i == 7)) begin n_fail++; $display("FAIL oneshot_irq[%0d]: got %0b expected %0b", i, irq, (i == 7)); end
      end
      repeat (2) begin
         idle_cycle();
         n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_hold: got %0b expected 1", irq); end
      end
      bus_op(1'b0, addr_ctrl, 32'h0, ack_s, rd_s);
      n_checks++; if (rd_s !== 32'h8) begin n_fail++; $display("FAIL oneshot_ctrl_after: got %0h expected 8", rd_s); end
      bus_op(1'b1, addr_ctrl, 32'h8, ack_s, rd_s);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear: got %0b expected 0", irq); end
   endtask

   task automatic test_autoreload();
      logic        ack_s;
      logic [31:0] rd_s;
      logic [31:0] exp_cnt [16];
      logic        exp_irq;
      exp_cnt = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3,
                  32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
      bus_op(1'b1, addr_preset, 32'd3, ack_s, rd_s);
      bus_op(1'b1, addr_ctrl, 32'hB, ack_s, rd_s);
      for (int i = 0; i < 16; i++) begin
         exp_irq = (i == 5) || (i == 10) || (i == 15);
         bus_op(1'b0, addr_count, 32'h0, ack_s, rd_s);
         n_checks++; if (rd_s !== exp_cnt[i]) begin n_fail++; $display("FAIL auto_count[%0d]: got %0d expected %0d", i, rd_s, exp_cnt[i]); end
         n_checks++; if (irq !== exp_irq) begin n_fail++; $display("FAIL auto_irq[%0d]: got %0b expected %0b", i, irq, exp_irq); end
      end
      bus_op(1'b1, addr_ctrl, 32'h0, ack_s, rd_s);
      repeat (3) idle_cycle();
   endtask

   task automatic test_masked();
      logic        ack_s;
      logic [31:0] rd_s;
      bus_op(1'b1, addr_preset, 32'd0, ack_s, rd_s);
      bus_op(1'b1, addr_ctrl, 32'h1, ack_s, rd_s);
      for (int i = 0; i < 6; i++) begin
         idle_cycle();
         n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq[%0d]: got %0b expected 0", i, irq); end
      end
      bus_op(1'b0, addr_ctrl, 32'h0, ack_s, rd_s);
      n_checks++; if (rd_s !== 32'h0) begin n_fail++; $display("FAIL masked_ctrl_after: got %0h expected 0", rd_s); end
      bus_op(1'b0, addr_count, 32'h0, ack_s, rd_s);
      n_checks++; if (rd_s !== 32'h0) begin n_fail++; $display("FAIL masked_count: got %0h expected 0", rd_s); end
      bus_op(1'b1, addr_ctrl, 32'h8, ack_s, rd_s);
      idle_cycle();
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL masked_irq_after_unmask: got %0b expected 0", irq); end
   endtask

   task automatic test_disable();
      logic        ack_s;
      logic [31:0] rd_s;
      bus_op(1'b1, addr_preset, 32'd100, ack_s, rd_s);
      bus_op(1'b1, addr_ctrl, 32'h9, ack_s, rd_s);
      repeat (10) idle_cycle();
      bus_op(1'b1, addr_ctrl, 32'h8, ack_s, rd_s);
      for (int i = 0; i < 2; i++) begin
         bus_op(1'b0, addr_count, 32'h0, ack_s, rd_s);
         n_checks++; if (rd_s !== 32'd91) begin n_fail++; $display("FAIL disable_count[%0d]: got %0d expected 91", i, rd_s); end
      end
      idle_cycle();
      bus_op(1'b0, addr_count, 32'h0, ack_s, rd_s);
      n_checks++; if (rd_s !== 32'd91) begin n_fail++; $display("FAIL disable_count_late: got %0d expected 91", rd_s); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL disable_irq: got %0b expected 0", irq); end
   endtask

   task automatic test_back_to_back();
      logic        ack_s;
      logic [31:0] rd_s;
      logic        w_v   [4];
      logic [1:0]  a_v   [4];
      logic [31:0] exp_r [4];
      w_v   = '{1'b1, 1'b0, 1'b1, 1'b0};
      a_v   = '{addr_count, addr_count, addr_rsvd, addr_rsvd};
      exp_r = '{32'd0, 32'd91, 32'd0, 32'd0};
      for (int i = 0; i < 4; i++) begin
         bus_op(w_v[i], a_v[i], 32'd7, ack_s, rd_s);
         n_checks++; if (ack_s !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %0b expected 1", i, ack_s); end
         n_checks++; if (rd_s !== exp_r[i]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %0h expected %0h", i, rd_s, exp_r[i]); end
      end
      idle_cycle();
      n_checks++; if (bus_if.ack !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_idle: got %0b expected 0", bus_if.ack); end
      bus_op(1'b0, addr_count, 32'h0, ack_s, rd_s);
      n_checks++; if (rd_s !== 32'd91) begin n_fail++; $display("FAIL b2b_count_unchanged: got %0d expected 91", rd_s); end
   endtask

   task automatic test_reset_mid();
      logic        ack_s;
      logic [31:0] rd_s;
      bus_op(1'b1, addr_preset, 32'd2, ack_s, rd_s);
      bus_op(1'b1, addr_ctrl, 32'h9, ack_s, rd_s);
      repeat (6) idle_cycle();
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rstmid_irq_before: got %0b expected 1", irq); end
      @(negedge clk);
      bus_if.req  = 1'b1;
      bus_if.we   = 1'b0;
      bus_if.addr = addr_preset;
      @(posedge clk);
      #1;
      n_checks++; if (bus_if.ack !== 1'b1 || bus_if.rdata !== 32'd2) begin n_fail++; $display("FAIL rstmid_read: got ack=%0b rdata=%0h expected ack=1 rdata=2", bus_if.ack, bus_if.rdata); end
      #2;
      rst = 1'b0;
      #1;
      n_checks++; if (bus_if.ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack: got %0b expected 0", bus_if.ack); end
      n_checks++; if (bus_if.rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %0h expected 0", bus_if.rdata); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq: got %0b expected 0", irq); end
      bus_if.req = 1'b0;
      repeat (2) idle_cycle();
      @(negedge clk);
      rst = 1'b1;
      idle_cycle();
      n_checks++; if (bus_if.ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_pending_ack: got %0b expected 0", bus_if.ack); end
      bus_op(1'b0, addr_ctrl, 32'h0, ack_s, rd_s);
      n_checks++; if (rd_s !== 32'h0) begin n_fail++; $display("FAIL rstmid_ctrl: got %0h expected 0", rd_s); end
      bus_op(1'b0, addr_preset, 32'h0, ack_s, rd_s);
      n_checks++; if (rd_s !== 32'h0) begin n_fail++; $display("FAIL rstmid_preset: got %0h expected 0", rd_s); end
   endtask

   initial begin
      bus_if.req   = 1'b0;
      bus_if.we    = 1'b0;
      bus_if.addr  = 2'd0;
      bus_if.wdata = 32'h0;
      test_reset();
      test_oneshot();
      test_autoreload();
      test_masked();
      test_disable();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
